// File: rtl/hs_fifo_stage_if.sv
// Handshake bundle for hs_fifo_stage: upstream req_l/ack_l/din and downstream req_r/ack_r/dout.
// slave is the FIFO's view; master is the view of the surrounding producer/consumer.
interface hs_fifo_stage_if #(
  parameter int data_width = 32
);
  logic                  req_l;
  logic                  ack_l;
  logic [data_width-1:0] din;
  logic                  req_r;
  logic                  ack_r;
  logic [data_width-1:0] dout;

  // A word moves upstream->FIFO at an edge where ack_l=1, and FIFO->downstream at an edge
  // where ack_r goes high. Acks are single-cycle pulses, and data is valid in the ack cycle.
  modport slave (
    output req_l, ack_r, dout,
    input  ack_l, din, req_r
  );

  modport master (
    input  req_l, ack_r, dout,
    output ack_l, din, req_r
  );
endinterface

// File: rtl/hs_fifo_stage.sv
// Elastic req/ack buffer stage. All outputs are registered. Define HS_FIFO_STAGE_STATS_EN
// to add the high_water and stall_cycles statistics outputs.
module hs_fifo_stage #(
  parameter int data_width = 32,
  parameter int addr_width = 2
) (
  input  logic                clk,
  input  logic                rst,
  hs_fifo_stage_if.slave      bus,
  output logic [addr_width:0] count,
  output logic                overflow
`ifdef HS_FIFO_STAGE_STATS_EN
  ,
  output logic [addr_width:0] high_water,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int DEPTH = 1 << addr_width;
  localparam int CW    = addr_width + 1;
  localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
  localparam logic [CW-1:0] HEADROOM_C = CW'(DEPTH - 1);

  logic [data_width-1:0] mem_q [DEPTH];
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  req_l_q, req_l_d;
  logic                  ack_r_q, ack_r_d;
  logic                  overflow_q, overflow_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  pop, drop, do_push;

  always_comb begin
    pop     = bus.req_r && !ack_r_q && (count_q != '0);
    // A push into a full buffer is only legal when the same edge frees a slot.
    drop    = bus.ack_l && (count_q == FULL_C) && !pop;
    do_push = bus.ack_l && !drop;

    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(do_push) - CW'(pop);
    // One slot of headroom absorbs an ack already in flight when req_l drops.
    req_l_d    = count_d < HEADROOM_C;
    ack_r_d    = pop;
    dout_d     = pop ? mem_q[rd_ptr_q] : dout_q;
    overflow_d = overflow_q || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      req_l_q    <= 1'b0;
      ack_r_q    <= 1'b0;
      overflow_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      req_l_q    <= req_l_d;
      ack_r_q    <= ack_r_d;
      overflow_q <= overflow_d;
      dout_q     <= dout_d;
    end
  end

  // Storage has no reset; the read of mem_q above sees the pre-edge word even when
  // a simultaneous push at full targets the same slot.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  assign bus.req_l = req_l_q;
  assign bus.ack_r = ack_r_q;
  assign bus.dout  = dout_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef HS_FIFO_STAGE_STATS_EN
  logic [CW-1:0] high_water_q;
  logic [31:0]   stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_water_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (count_d > high_water_q) begin
        high_water_q <= count_d;
      end
      if (bus.req_r && !ack_r_q && (count_q == '0) && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign high_water   = high_water_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hs_fifo_stage.sv
// Directed bench for hs_fifo_stage (depth 4): scoreboard queue of expected dout words,
// popped by a monitor on each ack_r pulse; occupancy/flag checks inline.
module tb_hs_fifo_stage;
  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic [AW:0]   count;
  logic          overflow;
`ifdef HS_FIFO_STAGE_STATS_EN
  logic [AW:0]   high_water;
  logic [31:0]   stall_cycles;
`endif

  hs_fifo_stage_if #(.data_width(DW)) bus ();

  hs_fifo_stage #(
    .data_width(DW),
    .addr_width(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .count       (count),
    .overflow    (overflow)
`ifdef HS_FIFO_STAGE_STATS_EN
    ,
    .high_water  (high_water),
    .stall_cycles(stall_cycles)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: single ack_l pulse carrying d
  task automatic push_word(input logic [DW-1:0] d, input bit expect_kept);
    bus.ack_l = 1'b1;
    bus.din   = d;
    if (expect_kept) exp_q.push_back(d);
    tick();
    bus.ack_l = 1'b0;
  endtask

  task automatic wait_drained(input int max_cycles);
    int n;
    n = 0;
    while (!(count == '0 && !bus.ack_r && exp_q.size() == 0) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < max_cycles), 32'd1);
  endtask

  // producer honouring req_l, with a given downstream req_r pattern
  task automatic stream(input logic [DW-1:0] first, input int nwords, input logic [7:0] rr_pat);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < nwords && cyc < 60) begin
      bus.req_r = rr_pat[cyc % 8];
      if (bus.req_l) begin
        bus.ack_l = 1'b1;
        bus.din   = first + DW'(sent);
        exp_q.push_back(first + DW'(sent));
        sent++;
      end else begin
        bus.ack_l = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.ack_l = 1'b0;
    check("stream_timeout", 32'(sent), 32'(nwords));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack_r) begin
        check("ack_r_gap", 32'(prev_ack), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack_r", 32'd1, 32'd0);
        end else begin
          check("dout", bus.dout, exp_q.pop_front());
        end
      end
      prev_ack = bus.ack_r;
    end else begin
      prev_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] fill_req_exp;

  initial begin
    rst       = 1'b1;
    bus.ack_l = 1'b0;
    bus.din   = '0;
    bus.req_r = 1'b0;
    tick();
    tick();
    check("rst_req_l", 32'(bus.req_l), 32'd0);
    check("rst_ack_r", 32'(bus.ack_r), 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef HS_FIFO_STAGE_STATS_EN
    check("rst_high_water", 32'(high_water), 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("req_l_after_reset", 32'(bus.req_l), 32'd1);

    // fill while stalled: req_l drops once count reaches 3, 4th in-flight word fits
    fill_req_exp = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      push_word(DW'(i), 1'b1);
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_req_l", 32'(bus.req_l), 32'(fill_req_exp[i]));
    end
    check("fill_overflow", 32'(overflow), 32'd0);
`ifdef HS_FIFO_STAGE_STATS_EN
    check("fill_high_water", 32'(high_water), 32'd4);
`endif

    // simultaneous push/pop at full: oldest word leaves, 9 queued last
    bus.req_r = 1'b1;
    push_word(32'd9, 1'b1);
    bus.req_r = 1'b0;
    check("simul_count", 32'(count), 32'd4);
    check("simul_overflow", 32'(overflow), 32'd0);
    check("simul_ack_r", 32'(bus.ack_r), 32'd1);
    tick();

    // overflow injection: push into full with no pop is dropped
    push_word(32'hDEAD, 1'b0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // drain: expect 1,2,3,9 on alternate cycles
    bus.req_r = 1'b1;
    wait_drained(30);
    check("drain_count", 32'(count), 32'd0);
    check("drain_dout_hold", bus.dout, 32'd9);
    check("drain_req_l", 32'(bus.req_l), 32'd1);
    tick();
    tick();
    check("empty_no_ack", 32'(bus.ack_r), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // minimum latency: ack_l at edge t, ack_r at edge t+1
    push_word(32'hA5, 1'b1);
    check("lat_t_ack_r", 32'(bus.ack_r), 32'd0);
    check("lat_t_count", 32'(count), 32'd1);
    tick();
    check("lat_t1_ack_r", 32'(bus.ack_r), 32'd1);
    check("lat_t1_count", 32'(count), 32'd0);
    tick();

    // streaming with a mixed downstream request pattern
    stream(32'h100, 10, 8'b1011_0110);
    bus.req_r = 1'b1;
    wait_drained(40);

    // reset mid-stream with two words buffered and an ack coinciding with rst
    bus.req_r = 1'b0;
    push_word(32'h20, 1'b0);
    push_word(32'h21, 1'b0);
    check("mid_count_before", 32'(count), 32'd2);
    rst       = 1'b1;
    bus.ack_l = 1'b1;
    bus.din   = 32'h77;
    tick();
    bus.ack_l = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ack_r", 32'(bus.ack_r), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_req_l", 32'(bus.req_l), 32'd0);
`ifdef HS_FIFO_STAGE_STATS_EN
    check("mid_rst_high_water", 32'(high_water), 32'd0);
    check("mid_rst_stall_cycles", stall_cycles, 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("mid_count_after", 32'(count), 32'd0);

    // restart in order from 0
    stream(32'd0, 6, 8'b1111_1111);
    bus.req_r = 1'b1;
    wait_drained(40);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
